ccu_cmd_sequencer: RTL and testbench
====================================

# ccu_cmd_sequencer

Command sequencer that sits in front of the CCU and drives its 8-bit `cmd` input. Upstream producers push commands with a per-command hold time into a small FIFO through a valid/ready handshake. The sequencer presents one command at a time to the CCU, holding each for its programmed number of cycles. When it has nothing queued it drives NOP (`8'h00`), so the CCU's `Kbus` sees a well-defined command stream every cycle.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `HOLD_W`, 4: width of the per-command hold field.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `cmd_in`  in  8: command to enqueue.
- `hold_in`  in  HOLD_W: extra cycles to hold `cmd_in` at the CCU.
- `cmd_valid`  in  1: producer offers `cmd_in`/`hold_in`.
- `cmd_ready`  out  1: FIFO can accept; equals `!full && !rst`.
- `cmd_out`  out  8: command to the CCU `cmd` port (registered).
- `issue`  out  1: one-cycle pulse in the first cycle a new command is on `cmd_out`.
- `busy`  out  1: a command (not NOP) is on `cmd_out`.
- `full`  out  1: FIFO holds DEPTH entries.
- `empty`  out  1: FIFO holds 0 entries.
- `count`  out  log2(DEPTH)+1: FIFO occupancy.
- `flush`  in  1: present only with `CCU_SEQ_FLUSH_EN`; see Configuration.

## Operation
- FIFO entry = {`hold_in`, `cmd_in`}. A push occurs on an edge where `cmd_valid && cmd_ready`.
- There is no bypass path. A pushed entry becomes poppable on the next edge.
- States:
  - IDLE: `cmd_out`=0, `busy`=0.
  - RUN: a command is active; down-counter `hcnt` is loaded from the entry's hold field.
- IDLE → RUN: on an edge with `!empty`. Pop the head, load `cmd_out`/`hcnt`, and assert `issue` for the following cycle.
- RUN with `hcnt`≠0: decrement `hcnt` each edge; `cmd_out` is unchanged.
- RUN with `hcnt`=0:
  - If `!empty`: pop the next entry back-to-back with no NOP gap, and pulse `issue` again.
  - Else: go to IDLE and drive `cmd_out`=0.
- Each command occupies `cmd_out` for exactly `hold+1` cycles. `hold`=0 gives one cycle.
- A command value of 0 is legal and is issued like any other command: it counts as `busy` and pulses `issue`.
- Simultaneous push and pop in one edge: `count` is unchanged and pointers advance independently. Because `cmd_ready`=0 when full, there is no push-while-full.
- Pointers wrap modulo DEPTH. `count` distinguishes full from empty.

## Timing
- Reset values: `cmd_out`=0, `issue`=0, `busy`=0, `count`=0, `empty`=1, `full`=0, state IDLE, pointers 0. `cmd_ready`=0 while `rst`=1.
- Reset mid-operation discards the FIFO contents and the active command. `cmd_out` reads 0 in the cycle after the reset edge.
- Latency: a push at edge N into an empty FIFO while IDLE puts the command on `cmd_out` with `issue`=1 after edge N+1.
- Sustained throughput is one command per `hold+1` cycles; the FIFO sustains a one-per-cycle producer until full.
- `issue`, `busy`, `full`, `empty` and `count` are all registered or derived from registers, with no combinational path from `cmd_valid`.

## Configuration
- `CCU_SEQ_FLUSH_EN` defined:
  - Adds the `flush` input.
  - `flush`=1 at an edge empties the FIFO (`count`=0), forces IDLE and sets `cmd_out`=0 next cycle.
  - A push in the same cycle is dropped, because `cmd_ready` is forced to 0 while `flush`=1.
  - `rst` has priority over `flush`.
- Not defined: the `flush` port does not exist, and the queue drains only by normal issue or by `rst`.

## Test plan
- Reset: hold `rst` for 2 cycles while `cmd_valid`=1 -> `cmd_ready`=0, `cmd_out`=0, `count`=0, no push.
- Single command: push cmd=2, hold=0 at edge N -> `cmd_out`=2 with `issue`=1 for exactly cycle N+1, then `cmd_out`=0, `busy`=0.
- Back-to-back holds: push (4,h=2),(6,h=0),(8,h=1) on consecutive cycles -> `cmd_out` sequence is 4,4,4,6,8,8,0, with `issue` pulses at the first 4, the 6 and the first 8.
- Full/backpressure: with DEPTH=8, push 10 commands (cmd 10..28 step 2, h=3) continuously -> `full`=1 and `cmd_ready`=0 once `count`=8; the stalled entries are accepted later; all 10 are issued in order with no loss or duplication across pointer wrap.
- Simultaneous push/pop: at `count`=3, push on the same edge as a pop -> `count` stays 3 and issue order is preserved.
- Flush (`CCU_SEQ_FLUSH_EN` only): assert `flush` mid-hold with `count`=5 -> next cycle `cmd_out`=0, `count`=0, `empty`=1; a subsequent push of cmd=76 issues normally.

Source files
------------

// File: rtl/ccu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// ccu_cmd_sequencer
//
// Purpose: queues {hold, cmd} entries from an upstream producer and plays them
// to the CCU cmd port one at a time. Each command stays on o_cmd_out for
// hold+1 cycles. When nothing is queued the port carries NOP (8'h00).
//
// Optional feature macro: CCU_SEQ_FLUSH_EN. When it is defined, the i_flush
// input is added. i_flush empties the queue and aborts the active command.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_flush      (CCU_SEQ_FLUSH_EN only) discard queue and active command
//   i_cmd_in     command to enqueue
//   i_hold_in    extra cycles to hold i_cmd_in at the CCU
//   i_cmd_valid  producer offers i_cmd_in/i_hold_in
//   o_cmd_ready  queue can accept (not full, not in reset/flush)
//   o_cmd_out    registered command to the CCU
//   o_issue      one-cycle pulse when a new command appears on o_cmd_out
//   o_busy       a command (possibly 8'h00) is active on o_cmd_out
//   o_full       queue holds DEPTH entries
//   o_empty      queue holds no entries
//   o_count      queue occupancy
// ---------------------------------------------------------------------------
module ccu_cmd_sequencer #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
`ifdef CCU_SEQ_FLUSH_EN
    input  logic                     i_flush,
`endif
    input  logic [7:0]               i_cmd_in,
    input  logic [HOLD_W-1:0]        i_hold_in,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    output logic [7:0]               o_cmd_out,
    output logic                     o_issue,
    output logic                     o_busy,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = HOLD_W + 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [HOLD_W-1:0] r_hcnt;
    logic [7:0]      r_cmd_out;
    logic            r_issue;

    logic            w_flush;
    logic            w_clear;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [EW-1:0]   w_head;

`ifdef CCU_SEQ_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    // Reset and flush share the same clearing path; reset is simply checked
    // alongside flush, so it always wins.
    assign w_clear = i_rst || w_flush;

    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign o_cmd_ready = !w_full && !i_rst && !w_flush;
    assign w_push      = i_cmd_valid && o_cmd_ready;
    assign w_head      = r_mem[r_rptr];

    assign o_cmd_out = r_cmd_out;
    assign o_issue   = r_issue;
    // Busy follows the FSM rather than the command value, since 8'h00 is a
    // legal command and must still count as busy.
    assign o_busy    = (r_state == S_RUN);
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state and pop decision. The pop only looks at registered
    // occupancy, so an entry pushed on an edge is not poppable until the
    // following edge.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_hcnt == '0) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Queue storage has no reset. Reset and flush only clear the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {i_hold_in, i_cmd_in};
        end
    end

    // Pointers, occupancy and the command output register
    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_cmd_out <= 8'h00;
            r_hcnt    <= '0;
            r_issue   <= 1'b0;
        end else begin
            r_issue <= w_pop;

            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end

            if (w_pop) begin
                r_rptr    <= r_rptr + AW'(1);
                r_cmd_out <= w_head[7:0];
                r_hcnt    <= w_head[EW-1:8];
            end else if (r_state == S_RUN) begin
                if (r_hcnt != '0) begin
                    r_hcnt <= r_hcnt - HOLD_W'(1);
                end else begin
                    // Hold expired with nothing queued: fall back to NOP.
                    r_cmd_out <= 8'h00;
                end
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ccu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ccu_cmd_sequencer
//
// Purpose: self-checking bench for ccu_cmd_sequencer. Accepted pushes go into
// an expected-command queue. A monitor running on the falling edge predicts
// issue, cmd_out, busy, count, full, empty and cmd_ready from that queue. A
// per-cycle vector table covers the single-command and back-to-back cases.
// Hand-written sequences cover reset, backpressure, simultaneous push/pop,
// a zero-valued command and, with CCU_SEQ_FLUSH_EN defined, flush.
// ---------------------------------------------------------------------------
module tb_ccu_cmd_sequencer;

    localparam int DEPTH  = 8;
    localparam int HOLD_W = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [7:0]        cmd_in = 8'h00;
    logic [HOLD_W-1:0] hold_in = '0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [7:0]        cmd_out;
    logic              issue;
    logic              busy;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;

    ccu_cmd_sequencer #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
`ifdef CCU_SEQ_FLUSH_EN
        .i_flush     (flush),
`endif
        .i_cmd_in    (cmd_in),
        .i_hold_in   (hold_in),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .o_cmd_out   (cmd_out),
        .o_issue     (issue),
        .o_busy      (busy),
        .o_full      (full),
        .o_empty     (empty),
        .o_count     (count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [HOLD_W+7:0] exp_q[$];
    logic [HOLD_W+7:0] head;
    int   cnt_m      = 0;
    bit   active     = 0;
    logic [7:0] cur_cmd = 8'h00;
    int   cur_left   = 0;
    bit   pushed_last = 0;
    bit   clr_last   = 1;   // the bench starts inside reset
    int   avail;
    bit   exp_iss;
    bit   clr_now;

    always @(negedge clk) begin
        if (clr_last) begin
            exp_q.delete();
            cnt_m       = 0;
            active      = 0;
            cur_left    = 0;
            pushed_last = 0;
            chk("clr_cmd_out", cmd_out, 0);
            chk("clr_issue", issue, 0);
            chk("clr_busy", busy, 0);
            chk("clr_count", count, 0);
            chk("clr_empty", empty, 1);
            chk("clr_full", full, 0);
        end else begin
            // An entry pushed on the edge just taken was not poppable yet.
            avail   = exp_q.size() - (pushed_last ? 1 : 0);
            exp_iss = (!active || cur_left <= 1) && (avail > 0);
            chk("mon_issue", issue, exp_iss);
            if (exp_iss) begin
                head     = exp_q.pop_front();
                cur_cmd  = head[7:0];
                cur_left = int'(head[HOLD_W+7:8]) + 1;
                active   = 1;
                cnt_m--;
            end else if (active && cur_left > 1) begin
                cur_left--;
            end else begin
                active = 0;
            end
            if (pushed_last) cnt_m++;
            chk("mon_cmd_out", cmd_out, active ? cur_cmd : 8'h00);
            chk("mon_busy", busy, active);
            chk("mon_count", count, cnt_m);
            chk("mon_full", full, cnt_m == DEPTH);
            chk("mon_empty", empty, cnt_m == 0);
        end
        clr_now = rst || flush;
        chk("mon_ready", cmd_ready, !clr_now && (cnt_m < DEPTH));
        pushed_last = !clr_now && cmd_valid && cmd_ready;
        if (pushed_last) exp_q.push_back({hold_in, cmd_in});
        clr_last = clr_now;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic v, input logic [7:0] c, input logic [HOLD_W-1:0] h);
        cmd_valid = v;
        cmd_in    = c;
        hold_in   = h;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit done = 0;
        cmd_valid = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            if (!busy && empty) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("wait_idle_timeout", done, 1);
    endtask

    typedef struct {
        logic              v;
        logic [7:0]        c;
        logic [HOLD_W-1:0] h;
        logic [7:0]        e_cmd;
        logic              e_iss;
    } vec_t;

    vec_t tbl[11];

    int  pushed;
    int  guard;
    bit  ready_now;
    bit  saw_full;
    bit  saw_stall;

    initial begin
        // rows 0..2: single command, cmd=2 hold=0
        tbl[0]  = '{1'b1, 8'd2, 4'd0, 8'd0, 1'b0};
        tbl[1]  = '{1'b0, 8'd0, 4'd0, 8'd2, 1'b1};
        tbl[2]  = '{1'b0, 8'd0, 4'd0, 8'd0, 1'b0};
        // rows 3..10: back-to-back (4,h2),(6,h0),(8,h1)
        tbl[3]  = '{1'b1, 8'd4, 4'd2, 8'd0, 1'b0};
        tbl[4]  = '{1'b1, 8'd6, 4'd0, 8'd4, 1'b1};
        tbl[5]  = '{1'b1, 8'd8, 4'd1, 8'd4, 1'b0};
        tbl[6]  = '{1'b0, 8'd0, 4'd0, 8'd4, 1'b0};
        tbl[7]  = '{1'b0, 8'd0, 4'd0, 8'd6, 1'b1};
        tbl[8]  = '{1'b0, 8'd0, 4'd0, 8'd8, 1'b1};
        tbl[9]  = '{1'b0, 8'd0, 4'd0, 8'd8, 1'b0};
        tbl[10] = '{1'b0, 8'd0, 4'd0, 8'd0, 1'b0};

        // Reset held for two cycles with a producer offering a command
        cmd_valid = 1'b1;
        cmd_in    = 8'h55;
        hold_in   = 4'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_cmd_out", cmd_out, 0);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 4'd0);
        chk("post_rst_empty", empty, 1);

        // Table-driven single and back-to-back sequences
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].v, tbl[i].c, tbl[i].h);
            chk($sformatf("tbl%0d_cmd", i), cmd_out, tbl[i].e_cmd);
            chk($sformatf("tbl%0d_issue", i), issue, tbl[i].e_iss);
        end
        wait_idle();

        // Full/backpressure: a long-hold command keeps the sequencer occupied
        // so the following ten pushes fill the queue and stall.
        cyc(1'b1, 8'h01, 4'hf);
        pushed    = 0;
        guard     = 0;
        saw_full  = 0;
        saw_stall = 0;
        while (pushed < 10 && guard < 300) begin
            ready_now = cmd_ready;
            if (full) saw_full = 1;
            if (!ready_now) saw_stall = 1;
            cyc(1'b1, 8'(10 + 2 * pushed), 4'd3);
            if (ready_now) pushed++;
            guard++;
        end
        cmd_valid = 1'b0;
        chk("bp_all_pushed", pushed, 10);
        chk("bp_saw_full", saw_full, 1);
        chk("bp_saw_stall", saw_stall, 1);
        wait_idle();

        // Simultaneous push and pop at count=3
        cyc(1'b1, 8'h30, 4'd3);
        cyc(1'b0, 8'h00, 4'd0);
        cyc(1'b1, 8'h31, 4'd0);
        cyc(1'b1, 8'h32, 4'd0);
        cyc(1'b1, 8'h33, 4'd0);
        chk("pp_count_before", count, 3);
        cyc(1'b1, 8'h34, 4'd0);
        chk("pp_count_after", count, 3);
        chk("pp_issue", issue, 1);
        chk("pp_cmd_out", cmd_out, 8'h31);
        wait_idle();

        // A zero-valued command is issued like any other
        cyc(1'b1, 8'h00, 4'd1);
        cyc(1'b0, 8'h00, 4'd0);
        chk("zero_issue", issue, 1);
        chk("zero_busy", busy, 1);
        cyc(1'b0, 8'h00, 4'd0);
        chk("zero_busy_hold", busy, 1);
        cyc(1'b0, 8'h00, 4'd0);
        chk("zero_done", busy, 0);

        // Reset in the middle of a hold with entries queued
        cyc(1'b1, 8'h50, 4'd5);
        cyc(1'b1, 8'h51, 4'd2);
        cyc(1'b1, 8'h52, 4'd2);
        cyc(1'b0, 8'h00, 4'd0);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 4'd0);
        rst = 1'b0;
        chk("mid_rst_cmd_out", cmd_out, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_busy", busy, 0);
        cyc(1'b0, 8'h00, 4'd0);
        chk("mid_rst_stays_idle", busy, 0);

`ifdef CCU_SEQ_FLUSH_EN
        // Flush mid-hold with five entries queued. The push offered alongside
        // the flush must be dropped.
        cyc(1'b1, 8'h40, 4'd7);
        cyc(1'b1, 8'h41, 4'd0);
        cyc(1'b1, 8'h42, 4'd0);
        cyc(1'b1, 8'h43, 4'd0);
        cyc(1'b1, 8'h44, 4'd0);
        cyc(1'b1, 8'h45, 4'd0);
        chk("fl_count_before", count, 5);
        flush = 1'b1;
        cyc(1'b1, 8'h99, 4'd0);
        flush = 1'b0;
        chk("fl_cmd_out", cmd_out, 0);
        chk("fl_count", count, 0);
        chk("fl_empty", empty, 1);
        cyc(1'b1, 8'd76, 4'd0);
        cyc(1'b0, 8'h00, 4'd0);
        chk("fl_next_cmd", cmd_out, 8'd76);
        chk("fl_next_issue", issue, 1);
        wait_idle();
`endif

        cyc(1'b0, 8'h00, 4'd0);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Hard time bound in case the stimulus itself gets stuck
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
